// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - shares one memory port between the CPU and a DMA requester
// CPU wins contention until it has starved the DMA for STARVE_MAX grants.
module mem_arbiter #(
    parameter int LAT        = 1,
    parameter int STARVE_MAX = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] cpu_adr,
    input  logic [31:0] cpu_wdata,
    input  logic        cpu_memread,
    input  logic        cpu_memwrite,
    output logic [31:0] cpu_rdata,
    output logic        cpu_stall,
    input  logic        dma_req,
    input  logic        dma_we,
    input  logic [31:0] dma_adr,
    input  logic [31:0] dma_wdata,
    output logic        dma_ack,
    output logic [31:0] dma_rdata,
    output logic [31:0] mem_adr,
    output logic [31:0] mem_wdata,
    output logic        mem_re,
    output logic        mem_we,
    input  logic [31:0] mem_rdata
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        CPU_BUSY = 2'd1,
        DMA_BUSY = 2'd2
    } state_t;

    localparam logic [2:0] LAST   = 3'(LAT - 1);
    localparam logic [7:0] SMAX   = 8'(STARVE_MAX);
    localparam logic       SINGLE = (LAT == 1);

    state_t      state;
    logic [2:0]  cnt;
    logic [7:0]  starve;
    logic [31:0] hold_adr;
    logic [31:0] hold_wdata;
    logic        hold_re;
    logic        hold_we;

    logic cpu_req;
    logic grant_cpu;
    logic grant_dma;
    logic final_beat;
    logic cpu_final;
    logic dma_final;

    assign cpu_req = cpu_memread | cpu_memwrite;

    // Grants are only ever issued from IDLE, so ownership cannot change mid-access.
    assign grant_dma = reset && (state == IDLE) && dma_req && (!cpu_req || (starve == SMAX));
    assign grant_cpu = reset && (state == IDLE) && cpu_req && !grant_dma;

    assign final_beat = (state == IDLE) ? SINGLE : (cnt == LAST);
    assign cpu_final  = final_beat && (grant_cpu || (state == CPU_BUSY));
    assign dma_final  = final_beat && (grant_dma || (state == DMA_BUSY));

    // Busy beats replay the values latched at grant so the access stays stable.
    always_comb begin
        mem_adr   = 32'd0;
        mem_wdata = 32'd0;
        mem_re    = 1'b0;
        mem_we    = 1'b0;
        if (grant_cpu) begin
            mem_adr   = cpu_adr;
            mem_wdata = cpu_wdata;
            mem_re    = cpu_memread;
            mem_we    = cpu_memwrite;
        end else if (grant_dma) begin
            mem_adr   = dma_adr;
            mem_wdata = dma_wdata;
            mem_re    = !dma_we;
            mem_we    = dma_we;
        end else if (reset && (state != IDLE)) begin
            mem_adr   = hold_adr;
            mem_wdata = hold_wdata;
            mem_re    = hold_re;
            mem_we    = hold_we;
        end
    end

    assign cpu_stall = reset && cpu_req && !cpu_final;
    assign dma_ack   = reset && dma_final;
    assign cpu_rdata = reset ? mem_rdata : 32'd0;
    assign dma_rdata = dma_ack ? mem_rdata : 32'd0;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            cnt        <= 3'd0;
            starve     <= 8'd0;
            hold_adr   <= 32'd0;
            hold_wdata <= 32'd0;
            hold_re    <= 1'b0;
            hold_we    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (grant_cpu && dma_req && (starve != SMAX)) begin
                        starve <= starve + 8'd1;
                    end
                    if (grant_dma) begin
                        starve <= 8'd0;
                    end
                    if ((grant_cpu || grant_dma) && !SINGLE) begin
                        state      <= grant_cpu ? CPU_BUSY : DMA_BUSY;
                        cnt        <= 3'd1;
                        hold_adr   <= mem_adr;
                        hold_wdata <= mem_wdata;
                        hold_re    <= mem_re;
                        hold_we    <= mem_we;
                    end
                end
                CPU_BUSY, DMA_BUSY: begin
                    if (cnt == LAST) begin
                        state      <= IDLE;
                        cnt        <= 3'd0;
                        hold_adr   <= 32'd0;
                        hold_wdata <= 32'd0;
                        hold_re    <= 1'b0;
                        hold_we    <= 1'b0;
                    end else begin
                        cnt <= cnt + 3'd1;
                    end
                end
                default: begin
                    state <= IDLE;
                    cnt   <= 3'd0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - scoreboard bench for mem_arbiter at LAT=1 and LAT=3
module tb_mem_arbiter;

    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    logic [31:0] qa_cpu[$];
    logic [31:0] qa_dma[$];
    logic [31:0] qb_cpu[$];
    logic [31:0] qb_dma[$];

    logic [31:0] a_cpu_adr = 0, a_cpu_wdata = 0, a_cpu_rdata, a_dma_adr = 0, a_dma_wdata = 0, a_dma_rdata;
    logic [31:0] a_mem_adr, a_mem_wdata, a_mem_rdata;
    logic        a_cpu_memread = 0, a_cpu_memwrite = 0, a_cpu_stall, a_dma_req = 0, a_dma_we = 0, a_dma_ack;
    logic        a_mem_re, a_mem_we;

    logic [31:0] b_cpu_adr = 0, b_cpu_wdata = 0, b_cpu_rdata, b_dma_adr = 0, b_dma_wdata = 0, b_dma_rdata;
    logic [31:0] b_mem_adr, b_mem_wdata, b_mem_rdata;
    logic        b_cpu_memread = 0, b_cpu_memwrite = 0, b_cpu_stall, b_dma_req = 0, b_dma_we = 0, b_dma_ack;
    logic        b_mem_re, b_mem_we;

    function automatic logic [31:0] mem_fn(input logic [31:0] a);
        if (a == 32'h40) return 32'h1234ABCD;
        if (a == 32'h100) return 32'hDEADBEEF;
        return {a[15:0] ^ 16'hBEEF, a[15:0]};
    endfunction

    assign a_mem_rdata = mem_fn(a_mem_adr);
    assign b_mem_rdata = mem_fn(b_mem_adr);

    mem_arbiter #(.LAT(1), .STARVE_MAX(4)) dut_a (
        .clk(clk), .reset(reset),
        .cpu_adr(a_cpu_adr), .cpu_wdata(a_cpu_wdata), .cpu_memread(a_cpu_memread),
        .cpu_memwrite(a_cpu_memwrite), .cpu_rdata(a_cpu_rdata), .cpu_stall(a_cpu_stall),
        .dma_req(a_dma_req), .dma_we(a_dma_we), .dma_adr(a_dma_adr), .dma_wdata(a_dma_wdata),
        .dma_ack(a_dma_ack), .dma_rdata(a_dma_rdata),
        .mem_adr(a_mem_adr), .mem_wdata(a_mem_wdata), .mem_re(a_mem_re), .mem_we(a_mem_we),
        .mem_rdata(a_mem_rdata)
    );

    mem_arbiter #(.LAT(3), .STARVE_MAX(2)) dut_b (
        .clk(clk), .reset(reset),
        .cpu_adr(b_cpu_adr), .cpu_wdata(b_cpu_wdata), .cpu_memread(b_cpu_memread),
        .cpu_memwrite(b_cpu_memwrite), .cpu_rdata(b_cpu_rdata), .cpu_stall(b_cpu_stall),
        .dma_req(b_dma_req), .dma_we(b_dma_we), .dma_adr(b_dma_adr), .dma_wdata(b_dma_wdata),
        .dma_ack(b_dma_ack), .dma_rdata(b_dma_rdata),
        .mem_adr(b_mem_adr), .mem_wdata(b_mem_wdata), .mem_re(b_mem_re), .mem_we(b_mem_we),
        .mem_rdata(b_mem_rdata)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Completion monitors pop the scoreboard whenever a read finishes.
    always @(negedge clk) begin
        if (reset) begin
            if (a_cpu_memread && !a_cpu_stall) begin
                if (qa_cpu.size() == 0) check("a_cpu_extra", 32'(qa_cpu.size()), 1);
                else check("a_cpu_rdata", a_cpu_rdata, qa_cpu.pop_front());
            end
            if (a_dma_ack) begin
                if (qa_dma.size() == 0) check("a_dma_extra", 32'(qa_dma.size()), 1);
                else check("a_dma_rdata", a_dma_rdata, qa_dma.pop_front());
            end
            if (b_cpu_memread && !b_cpu_stall) begin
                if (qb_cpu.size() == 0) check("b_cpu_extra", 32'(qb_cpu.size()), 1);
                else check("b_cpu_rdata", b_cpu_rdata, qb_cpu.pop_front());
            end
            if (b_dma_ack) begin
                if (qb_dma.size() == 0) check("b_dma_extra", 32'(qb_dma.size()), 1);
                else check("b_dma_rdata", b_dma_rdata, qb_dma.pop_front());
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // Requests present during reset must not leak to any output.
        a_cpu_memread = 1; a_cpu_adr = 32'h40;
        b_cpu_memwrite = 1; b_cpu_adr = 32'h80; b_cpu_wdata = 32'h55;
        b_dma_req = 1; b_dma_adr = 32'h100;
        @(negedge clk);
        check("rst_a_mem_re", a_mem_re, 0);
        check("rst_a_stall", a_cpu_stall, 0);
        check("rst_a_rdata", a_cpu_rdata, 0);
        check("rst_b_mem_we", b_mem_we, 0);
        check("rst_b_mem_adr", b_mem_adr, 0);
        check("rst_b_stall", b_cpu_stall, 0);
        check("rst_b_ack", b_dma_ack, 0);
        a_cpu_memread = 0;
        b_cpu_memwrite = 0; b_dma_req = 0;
        step();
        reset = 1;
        step();

        // Pass-through at LAT=1.
        a_cpu_memread = 1; a_cpu_adr = 32'h40;
        qa_cpu.push_back(32'h1234ABCD);
        @(negedge clk);
        check("pass_mem_re", a_mem_re, 1);
        check("pass_mem_adr", a_mem_adr, 32'h40);
        check("pass_stall", a_cpu_stall, 0);
        step();
        a_cpu_memread = 0;

        // Starvation at LAT=1, STARVE_MAX=4: four CPU grants then one DMA grant.
        a_cpu_memread = 1; a_cpu_adr = 32'h44;
        a_dma_req = 1; a_dma_we = 0; a_dma_adr = 32'h100;
        for (int i = 0; i < 8; i++) qa_cpu.push_back(mem_fn(32'h44));
        for (int i = 0; i < 2; i++) qa_dma.push_back(32'hDEADBEEF);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check($sformatf("starve_ack_%0d", i), a_dma_ack, (i % 5 == 4));
            check($sformatf("starve_stall_%0d", i), a_cpu_stall, (i % 5 == 4));
            check($sformatf("starve_adr_%0d", i), a_mem_adr, (i % 5 == 4) ? 32'h100 : 32'h44);
            step();
        end
        a_cpu_memread = 0; a_dma_req = 0;

        // Wait states at LAT=3: CPU write holds the bus for three beats.
        b_cpu_memwrite = 1; b_cpu_adr = 32'h80; b_cpu_wdata = 32'h55;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check($sformatf("ws_stall_%0d", i), b_cpu_stall, (i < 2));
            check($sformatf("ws_we_%0d", i), b_mem_we, 1);
            check($sformatf("ws_adr_%0d", i), b_mem_adr, 32'h80);
            check($sformatf("ws_wdata_%0d", i), b_mem_wdata, 32'h55);
            step();
        end
        b_cpu_memwrite = 0;
        @(negedge clk);
        check("ws_idle_we", b_mem_we, 0);
        check("ws_idle_adr", b_mem_adr, 0);
        step();

        // DMA read alone; a CPU read raised in beat 1 waits until after the DMA final beat.
        b_dma_req = 1; b_dma_we = 0; b_dma_adr = 32'h100;
        qb_dma.push_back(32'hDEADBEEF);
        for (int i = 0; i < 6; i++) begin
            if (i == 1) begin
                b_cpu_memread = 1; b_cpu_adr = 32'h48;
                qb_cpu.push_back(mem_fn(32'h48));
            end
            if (i == 3) b_dma_req = 0;
            @(negedge clk);
            check($sformatf("dma_ack_%0d", i), b_dma_ack, (i == 2));
            check($sformatf("dma_adr_%0d", i), b_mem_adr, (i < 3) ? 32'h100 : 32'h48);
            check($sformatf("dma_re_%0d", i), b_mem_re, 1);
            if (i >= 1) check($sformatf("dma_stall_%0d", i), b_cpu_stall, (i != 5));
            step();
        end
        b_cpu_memread = 0;

        // Simultaneous requests from starve=0 with STARVE_MAX=2: C, C, D repeating.
        b_cpu_memread = 1; b_cpu_adr = 32'h4C;
        b_dma_req = 1; b_dma_adr = 32'h104;
        for (int i = 0; i < 4; i++) qb_cpu.push_back(mem_fn(32'h4C));
        for (int i = 0; i < 2; i++) qb_dma.push_back(mem_fn(32'h104));
        for (int i = 0; i < 18; i++) begin
            @(negedge clk);
            check($sformatf("sim_ack_%0d", i), b_dma_ack, ((i / 3) % 3 == 2) && (i % 3 == 2));
            check($sformatf("sim_stall_%0d", i), b_cpu_stall, !(((i / 3) % 3 != 2) && (i % 3 == 2)));
            check($sformatf("sim_adr_%0d", i), b_mem_adr, ((i / 3) % 3 == 2) ? 32'h104 : 32'h4C);
            step();
        end
        b_cpu_memread = 0; b_dma_req = 0;
        step();

        // Reset in the middle of a DMA access: outputs clear at once, no ack afterwards.
        b_dma_req = 1; b_dma_adr = 32'h108;
        @(negedge clk);
        check("mid_grant_re", b_mem_re, 1);
        step();
        b_cpu_memread = 1; b_cpu_adr = 32'h50;
        #1;
        check("mid_busy_stall", b_cpu_stall, 1);
        reset = 0;
        #1;
        check("mid_rst_re", b_mem_re, 0);
        check("mid_rst_adr", b_mem_adr, 0);
        check("mid_rst_stall", b_cpu_stall, 0);
        check("mid_rst_ack", b_dma_ack, 0);
        check("mid_rst_rdata", b_cpu_rdata, 0);
        b_cpu_memread = 0; b_dma_req = 0;
        step();
        reset = 1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check($sformatf("post_re_%0d", i), b_mem_re, 0);
            check($sformatf("post_we_%0d", i), b_mem_we, 0);
            check($sformatf("post_ack_%0d", i), b_dma_ack, 0);
            step();
        end

        check("drain_a_cpu", 32'(qa_cpu.size()), 0);
        check("drain_a_dma", 32'(qa_dma.size()), 0);
        check("drain_b_cpu", 32'(qb_cpu.size()), 0);
        check("drain_b_dma", 32'(qb_dma.size()), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
